fetch_buffer: RTL

Parametrised instruction-fetch front end. It issues line-sized burst reads on the system bus and fills a circular byte buffer. It presents a window of up to WINDOW bytes at the decode head and accepts variable-length consumption. New relative to the single-width fetch loop:
- configurable bus/line/buffer widths
- redirect (flush plus re-steer) with drain of an in-flight burst
- byte-accurate handling of unaligned entry points

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_buffer_if.sv | 34 +++
 rtl/fetch_byte_ring.sv | 50 +++++
 rtl/fetch_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, defaults and address helpers for the
// instruction-fetch front end.
package fetch_pkg;

    localparam int DEF_BUS_W      = 64;
    localparam int DEF_LINE_BYTES = 64;
    localparam int DEF_BUF_BYTES  = 128;
    localparam int DEF_WINDOW     = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        ACTIVE,
        DRAIN
    } fetch_state_t;

    function automatic logic [63:0] line_align(
        input logic [63:0] a,
        input int unsigned lb
    );
        return a & ~(64'(lb) - 64'd1);
    endfunction

    // Index of the beat holding address a within its line.
    function automatic logic [63:0] beat_offset(
        input logic [63:0] a,
        input int unsigned lb,
        input int unsigned bb
    );
        return (a & (64'(lb) - 64'd1)) / 64'(bb);
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Burst-read bus between the fetch buffer (master)
// and the memory system (slave).
interface fetch_buffer_if
    import fetch_pkg::*;
#(
    parameter int BUS_W = DEF_BUS_W
) ();

    logic             req_cyc;
    logic [63:0]      req_addr;
    logic             req_ack;
    logic             resp_cyc;
    logic [BUS_W-1:0] resp_data;
    logic             resp_ack;

    modport master (
        output req_cyc,
        output req_addr,
        output resp_ack,
        input  req_ack,
        input  resp_cyc,
        input  resp_data
    );

    modport slave (
        input  req_cyc,
        input  req_addr,
        input  resp_ack,
        output req_ack,
        output resp_cyc,
        output resp_data
    );

endinterface

// File: rtl/fetch_byte_ring.sv
// Circular byte store: masked beat write at the tail,
// wrap-aware WINDOW-byte read at the head.
module fetch_byte_ring
    import fetch_pkg::*;
#(
    parameter int BUS_W     = DEF_BUS_W,
    parameter int BUF_BYTES = DEF_BUF_BYTES,
    parameter int WINDOW    = DEF_WINDOW,
    localparam int BB       = BUS_W / 8,
    localparam int AW       = $clog2(BUF_BYTES),
    localparam int OW       = (BB > 1) ? $clog2(BB) : 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      wr_idx,
    input  logic [OW-1:0]      sub_off,
    input  logic [BUS_W-1:0]   wdata,
    input  logic [AW-1:0]      rd_idx,
    output logic [0:WINDOW*8-1] win
);

    logic [7:0] mem_q [BUF_BYTES];
    logic [7:0] mem_d [BUF_BYTES];

    // Bytes below sub_off are dropped; the rest pack down
    // contiguously from wr_idx.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = 0; i < BB; i++) begin
                if (i >= int'(sub_off)) begin
                    mem_d[AW'(int'(wr_idx) + i - int'(sub_off))] =
                        wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < WINDOW; i++) begin
            win[i*8 +: 8] = mem_q[AW'(int'(rd_idx) + i)];
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: line bursts into a byte ring,
// variable-length consume, redirect with burst drain.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int BUS_W      = DEF_BUS_W,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int BUF_BYTES  = DEF_BUF_BYTES,
    parameter int WINDOW     = DEF_WINDOW,
    localparam int CW        = $clog2(WINDOW + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         entry,
    fetch_buffer_if.master      bus,
    output logic [0:WINDOW*8-1] win_bytes,
    output logic [CW-1:0]       win_count,
    output logic [63:0]         win_addr,
    input  logic                consume,
    input  logic [CW-1:0]       consume_cnt,
    input  logic                redirect,
    input  logic [63:0]         redirect_addr
);

    localparam int BB    = BUS_W / 8;
    localparam int BEATS = LINE_BYTES / BB;
    localparam int AW    = $clog2(BUF_BYTES);
    localparam int PW    = AW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OW    = (BB > 1) ? $clog2(BB) : 1;

    fetch_state_t  state_q, state_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] skip_q, skip_d;
    logic [OW-1:0] sub_q, sub_d;
    logic [63:0]   line_q, line_d;
    logic [63:0]   waddr_q, waddr_d;
    logic          req_cyc_q, req_cyc_d;
    logic [63:0]   req_addr_q, req_addr_d;
    logic [CW-1:0] wcnt_q, wcnt_d;

    logic          wr_en;
    logic          beat_last;
    logic [PW-1:0] occ_d;
    logic [PW-1:0] free_d;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        beat_d  = beat_q;
        skip_d  = skip_q;
        sub_d   = sub_q;
        line_d  = line_q;
        waddr_d = waddr_q;
        wr_en   = 1'b0;

        beat_last = (beat_q == BW'(BEATS - 1));

        if (consume) begin
            rd_d    = rd_q + PW'(consume_cnt);
            waddr_d = waddr_q + 64'(consume_cnt);
        end

        unique case (state_q)
            IDLE: begin
                if (req_cyc_q && bus.req_ack) begin
                    state_d = WAITING;
                end
            end
            WAITING, ACTIVE: begin
                if (bus.resp_cyc) begin
                    state_d = ACTIVE;
                    if (skip_q != '0) begin
                        skip_d = skip_q - 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        wr_d  = wr_q + (PW'(BB) - PW'(sub_q));
                        sub_d = '0;
                    end
                    beat_d = beat_q + 1'b1;
                    if (beat_last) begin
                        line_d  = line_q + 64'(LINE_BYTES);
                        beat_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.resp_cyc) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_last) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: ;
        endcase

        // Redirect wins; an accepted or in-flight burst
        // must still be drained beat by beat.
        if (redirect) begin
            wr_en   = 1'b0;
            rd_d    = '0;
            wr_d    = '0;
            waddr_d = redirect_addr;
            line_d  = line_align(redirect_addr, LINE_BYTES);
            skip_d  = BW'(beat_offset(redirect_addr,
                                      LINE_BYTES, BB));
            sub_d   = OW'(redirect_addr & 64'(BB - 1));
            if (state_d == WAITING || state_d == ACTIVE) begin
                state_d = DRAIN;
            end
        end
    end

    always_comb begin
        occ_d  = wr_d - rd_d;
        free_d = PW'(BUF_BYTES) - occ_d;
        wcnt_d = (occ_d > PW'(WINDOW)) ? CW'(WINDOW)
                                       : CW'(occ_d);
        req_cyc_d = (state_d == IDLE) && !redirect &&
                    (free_d >= PW'(LINE_BYTES));
        req_addr_d = (state_d == IDLE) ? line_d : req_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wr_q       <= '0;
            beat_q     <= '0;
            skip_q     <= BW'(beat_offset(entry, LINE_BYTES, BB));
            sub_q      <= OW'(entry & 64'(BB - 1));
            line_q     <= line_align(entry, LINE_BYTES);
            waddr_q    <= entry;
            req_cyc_q  <= 1'b0;
            req_addr_q <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            beat_q     <= beat_d;
            skip_q     <= skip_d;
            sub_q      <= sub_d;
            line_q     <= line_d;
            waddr_q    <= waddr_d;
            req_cyc_q  <= req_cyc_d;
            req_addr_q <= req_addr_d;
            wcnt_q     <= wcnt_d;
        end
    end

    fetch_byte_ring #(
        .BUS_W     (BUS_W),
        .BUF_BYTES (BUF_BYTES),
        .WINDOW    (WINDOW)
    ) u_ring (
        .clk     (clk),
        .we      (wr_en),
        .wr_idx  (wr_q[AW-1:0]),
        .sub_off (sub_q),
        .wdata   (bus.resp_data),
        .rd_idx  (rd_q[AW-1:0]),
        .win     (win_bytes)
    );

    assign bus.req_cyc  = req_cyc_q;
    assign bus.req_addr = req_addr_q;
    assign bus.resp_ack = bus.resp_cyc;
    assign win_count    = wcnt_q;
    assign win_addr     = waddr_q;

    a_no_beat_idle: assert property (
        @(posedge clk) disable iff (!reset)
        !(state_q == IDLE && bus.resp_cyc)
    ) else $fatal(1, "resp_cyc while IDLE");

    a_consume_range: assert property (
        @(posedge clk) disable iff (!reset)
        !(consume && (consume_cnt > win_count))
    ) else $fatal(1, "consume_cnt exceeds win_count");

endmodule
